// File: rtl/eth_demux_type_ctrl.sv
// eth_demux_type_ctrl
//   Per-frame routing controller for eth_demux. Taps the demux input header
//   and payload handshakes and classifies each frame by EtherType against a
//   programmable match table. It drives the demux enable/drop/select
//   controls and holds each decision from before header acceptance until the
//   frame's last payload beat transfers.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   s_eth_hdr_valid/ready       header handshake tap
//   s_eth_type                  EtherType tap (sampled in LOOKUP only)
//   s_eth_payload_axis_t*       payload handshake tap (valid/ready/last)
//   ctrl_enable                 gates the start of new frames
//   cfg_type/cfg_mask           per-entry match value and compare mask
//   cfg_entry_en                per-entry valid
//   enable, drop, select        demux controls (registered)
//   busy                        controller is not idle
//   frame_routed/dropped        one-cycle completion pulses
//   drop_count                  saturating dropped-frame counter
module eth_demux_type_ctrl #(
    parameter int M_COUNT        = 4,
    parameter int SELECT_WIDTH   = $clog2(M_COUNT),
    parameter int DEFAULT_SELECT = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_eth_hdr_valid,
    input  logic                    s_eth_hdr_ready,
    input  logic [15:0]             s_eth_type,
    input  logic                    s_eth_payload_axis_tvalid,
    input  logic                    s_eth_payload_axis_tready,
    input  logic                    s_eth_payload_axis_tlast,
    input  logic                    ctrl_enable,
    input  logic [M_COUNT*16-1:0]   cfg_type,
    input  logic [M_COUNT*16-1:0]   cfg_mask,
    input  logic [M_COUNT-1:0]      cfg_entry_en,
    output logic                    enable,
    output logic                    drop,
    output logic [SELECT_WIDTH-1:0] select,
    output logic                    busy,
    output logic                    frame_routed,
    output logic                    frame_dropped,
    output logic [31:0]             drop_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_ROUTE,
        ST_PAYLOAD
    } state_t;

    state_t                  state_q, state_d;
    logic                    enable_q, enable_d;
    logic                    drop_q, drop_d;
    logic [SELECT_WIDTH-1:0] select_q, select_d;
    logic                    busy_q, busy_d;
    logic                    frame_routed_q, frame_routed_d;
    logic                    frame_dropped_q, frame_dropped_d;
    logic [31:0]             drop_count_q, drop_count_d;

    logic                    hit;
    logic [SELECT_WIDTH-1:0] hit_sel;
    logic                    hdr_hs;
    logic                    last_hs;

    assign hdr_hs  = s_eth_hdr_valid && s_eth_hdr_ready;
    assign last_hs = s_eth_payload_axis_tvalid && s_eth_payload_axis_tready &&
                     s_eth_payload_axis_tlast;

    // Scan from the top entry down so the lowest matching index is the one
    // left standing when the loop finishes.
    always_comb begin
        hit     = 1'b0;
        hit_sel = '0;
        for (int i = M_COUNT - 1; i >= 0; i--) begin
            if (cfg_entry_en[i] &&
                ((s_eth_type ^ cfg_type[16*i +: 16]) & cfg_mask[16*i +: 16]) == 16'h0) begin
                hit     = 1'b1;
                hit_sel = SELECT_WIDTH'(i);
            end
        end
    end

    // NOTE: every *_d gets a default before the case so no path leaves a
    // variable unassigned; otherwise synthesis infers latches.
    always_comb begin
        state_d         = state_q;
        enable_d        = enable_q;
        drop_d          = drop_q;
        select_d        = select_q;
        frame_routed_d  = 1'b0;
        frame_dropped_d = 1'b0;
        drop_count_d    = drop_count_q;

        case (state_q)
            ST_IDLE: begin
                enable_d = 1'b0;
                if (s_eth_hdr_valid && ctrl_enable) begin
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (hit) begin
                    select_d = hit_sel;
                    drop_d   = 1'b0;
                end else begin
                    select_d = SELECT_WIDTH'(DEFAULT_SELECT);
                    drop_d   = 1'b1;
                end
                enable_d = 1'b1;
                state_d  = ST_ROUTE;
            end
            ST_ROUTE: begin
                if (hdr_hs) begin
                    enable_d = 1'b0;
                    // A single-beat frame can finish in the header cycle.
                    state_d  = last_hs ? ST_IDLE : ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                enable_d = 1'b0;
                if (last_hs) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Completion is any transition back to IDLE; select/drop stay held.
        if (state_q != ST_IDLE && state_q != ST_LOOKUP && state_d == ST_IDLE) begin
            if (drop_q) begin
                frame_dropped_d = 1'b1;
                if (drop_count_q != 32'hFFFF_FFFF) begin
                    drop_count_d = drop_count_q + 32'd1;
                end
            end else begin
                frame_routed_d = 1'b1;
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            enable_q        <= 1'b0;
            drop_q          <= 1'b0;
            select_q        <= '0;
            busy_q          <= 1'b0;
            frame_routed_q  <= 1'b0;
            frame_dropped_q <= 1'b0;
            drop_count_q    <= 32'h0;
        end else begin
            state_q         <= state_d;
            enable_q        <= enable_d;
            drop_q          <= drop_d;
            select_q        <= select_d;
            busy_q          <= busy_d;
            frame_routed_q  <= frame_routed_d;
            frame_dropped_q <= frame_dropped_d;
            drop_count_q    <= drop_count_d;
        end
    end

    assign enable        = enable_q;
    assign drop          = drop_q;
    assign select        = select_q;
    assign busy          = busy_q;
    assign frame_routed  = frame_routed_q;
    assign frame_dropped = frame_dropped_q;
    assign drop_count    = drop_count_q;

endmodule

// File: tb/tb_eth_demux_type_ctrl.sv
// Testbench for eth_demux_type_ctrl: directed scenarios plus randomized
// frames, checked against a per-frame reference model of the match table.
module tb_eth_demux_type_ctrl;

    localparam int M       = 4;
    localparam int SW      = 2;
    localparam int DEF_SEL = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            hdr_valid, hdr_ready;
    logic [15:0]     etype;
    logic            tvalid, tready, tlast;
    logic            ctrl_en;
    logic [15:0]     cfg_t [M];
    logic [15:0]     cfg_m [M];
    logic [M-1:0]    cfg_en;
    logic [M*16-1:0] cfg_type_f, cfg_mask_f;

    logic            enable, drop, busy, frame_routed, frame_dropped;
    logic [SW-1:0]   select;
    logic [31:0]     drop_count;

    int              n_checks = 0;
    int              n_pass   = 0;
    logic [31:0]     ref_drops;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < M; i++) begin
            cfg_type_f[16*i +: 16] = cfg_t[i];
            cfg_mask_f[16*i +: 16] = cfg_m[i];
        end
    end

    eth_demux_type_ctrl #(
        .M_COUNT(M), .SELECT_WIDTH(SW), .DEFAULT_SELECT(DEF_SEL)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .s_eth_hdr_valid          (hdr_valid),
        .s_eth_hdr_ready          (hdr_ready),
        .s_eth_type               (etype),
        .s_eth_payload_axis_tvalid(tvalid),
        .s_eth_payload_axis_tready(tready),
        .s_eth_payload_axis_tlast (tlast),
        .ctrl_enable              (ctrl_en),
        .cfg_type                 (cfg_type_f),
        .cfg_mask                 (cfg_mask_f),
        .cfg_entry_en             (cfg_en),
        .enable                   (enable),
        .drop                     (drop),
        .select                   (select),
        .busy                     (busy),
        .frame_routed             (frame_routed),
        .frame_dropped            (frame_dropped),
        .drop_count               (drop_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference classification: first enabled entry whose masked bits agree.
    // Returns {drop, select}.
    function automatic logic [SW:0] ref_route(input logic [15:0] t);
        for (int i = 0; i < M; i++) begin
            if (cfg_en[i] && ((t & cfg_m[i]) == (cfg_t[i] & cfg_m[i])))
                return {1'b0, SW'(i)};
        end
        return {1'b1, SW'(DEF_SEL)};
    endfunction

    task automatic randomize_cfg();
        for (int i = 0; i < M; i++) begin
            cfg_t[i] = 16'($urandom);
            case ($urandom_range(0, 3))
                0: cfg_m[i] = 16'hFFFF;
                1: cfg_m[i] = 16'hFF00;
                2: cfg_m[i] = 16'h00FF;
                default: cfg_m[i] = 16'($urandom);
            endcase
        end
        cfg_en = 4'($urandom);
    endtask

    // Drives one frame starting from IDLE (called just after a negedge) and
    // checks timing, decision stability and completion.
    task automatic run_frame(input logic [15:0] t, input int beats, input int stall,
                             input bit cfg_change);
        logic [SW:0]   r;
        logic          exp_drop;
        logic [SW-1:0] exp_sel;
        r        = ref_route(t);
        exp_drop = r[SW];
        exp_sel  = r[SW-1:0];

        hdr_valid = 1'b1; hdr_ready = 1'b0; etype = t;
        @(negedge clk);                       // LOOKUP
        check("busy_lookup", 32'(busy), 32'd1);
        check("enable_lookup", 32'(enable), 32'd0);
        @(negedge clk);                       // first ROUTE cycle
        etype = 16'($urandom);
        check("enable_route", 32'(enable), 32'd1);
        check("select_route", 32'(select), 32'(exp_sel));
        check("drop_route", 32'(drop), 32'(exp_drop));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("enable_stall", 32'(enable), 32'd1);
            check("select_stall", 32'(select), 32'(exp_sel));
        end
        hdr_ready = 1'b1;
        if (beats == 1) begin
            tvalid = 1'b1; tready = 1'b1; tlast = 1'b1;
        end
        @(negedge clk);
        hdr_valid = 1'b0; hdr_ready = 1'b0;
        if (beats > 1) begin
            check("enable_payload", 32'(enable), 32'd0);
            check("busy_payload", 32'(busy), 32'd1);
            if (cfg_change) randomize_cfg();
            for (int b = 0; b < beats; b++) begin
                if ($urandom_range(0, 1) == 1) begin
                    // Stalled beat: valid without ready, even with tlast.
                    tvalid = 1'b1; tready = 1'b0; tlast = 1'b1;
                    @(negedge clk);
                    check("no_pulse_stall", 32'(frame_routed | frame_dropped), 32'd0);
                end
                tvalid = 1'b1; tready = 1'b1; tlast = (b == beats - 1);
                @(negedge clk);
                if (b < beats - 1) begin
                    check("select_hold", 32'(select), 32'(exp_sel));
                    check("drop_hold", 32'(drop), 32'(exp_drop));
                end
            end
        end
        tvalid = 1'b0; tlast = 1'b0; tready = 1'b0;
        // State is back in IDLE here with the completion pulse.
        if (exp_drop && ref_drops != 32'hFFFF_FFFF) ref_drops++;
        check("frame_dropped", 32'(frame_dropped), 32'(exp_drop));
        check("frame_routed", 32'(frame_routed), 32'(!exp_drop));
        check("drop_count", drop_count, ref_drops);
        check("busy_done", 32'(busy), 32'd0);
        check("select_after", 32'(select), 32'(exp_sel));
        check("drop_after", 32'(drop), 32'(exp_drop));
        @(negedge clk);
        check("pulse_cleared", 32'(frame_routed | frame_dropped), 32'd0);
    endtask

    initial begin
        rst = 1'b1; hdr_valid = 1'b0; hdr_ready = 1'b0; etype = 16'h0;
        tvalid = 1'b0; tready = 1'b0; tlast = 1'b0; ctrl_en = 1'b1;
        for (int i = 0; i < M; i++) begin cfg_t[i] = 16'h0; cfg_m[i] = 16'h0; end
        cfg_en = '0;
        ref_drops = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_enable", 32'(enable), 32'd0);
        check("rst_drop", 32'(drop), 32'd0);
        check("rst_select", 32'(select), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_routed", 32'(frame_routed), 32'd0);
        check("rst_dropped", 32'(frame_dropped), 32'd0);
        check("rst_count", drop_count, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Routed frame to entry 2.
        cfg_t[2] = 16'h0800; cfg_m[2] = 16'hFFFF; cfg_en = 4'b0100;
        run_frame(16'h0800, 4, 0, 1'b0);

        // Priority with mask, header back-pressure, cfg change mid-frame.
        cfg_t[1] = 16'h86DD; cfg_m[1] = 16'hFF00;
        cfg_t[3] = 16'h86DD; cfg_m[3] = 16'hFFFF; cfg_en = 4'b1010;
        run_frame(16'h8600, 3, 5, 1'b1);

        // Miss.
        cfg_en = 4'b0000;
        run_frame(16'h0806, 2, 0, 1'b0);

        // Single-beat frame, header and tlast in the same cycle.
        cfg_t[0] = 16'h1234; cfg_m[0] = 16'hFFFF; cfg_en = 4'b0001;
        run_frame(16'h1234, 1, 2, 1'b0);

        // ctrl_enable low blocks frame start.
        ctrl_en = 1'b0; hdr_valid = 1'b1; etype = 16'h1234;
        repeat (3) begin
            @(negedge clk);
            check("gate_busy", 32'(busy), 32'd0);
            check("gate_enable", 32'(enable), 32'd0);
        end
        hdr_valid = 1'b0; ctrl_en = 1'b1;

        // Payload handshakes in IDLE are ignored.
        tvalid = 1'b1; tready = 1'b1; tlast = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("idle_payload_pulse", 32'(frame_routed | frame_dropped), 32'd0);
            check("idle_payload_count", drop_count, ref_drops);
        end
        tvalid = 1'b0; tready = 1'b0; tlast = 1'b0;
        @(negedge clk);

        // Randomized frames against the reference model.
        for (int n = 0; n < 16; n++) begin
            logic [15:0] t;
            randomize_cfg();
            if ($urandom_range(0, 1) == 1)
                t = cfg_t[$urandom_range(0, M - 1)] ^ 16'($urandom_range(0, 3));
            else
                t = 16'($urandom);
            run_frame(t, int'($urandom_range(1, 5)), int'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)));
        end

        // Saturation of the drop counter.
        cfg_en = 4'b0000;
        force dut.drop_count_q = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.drop_count_q;
        ref_drops = 32'hFFFF_FFFE;
        check("sat_preload", drop_count, 32'hFFFF_FFFE);
        for (int n = 0; n < 3; n++) run_frame(16'h0806, 2, 0, 1'b0);
        check("sat_final", drop_count, 32'hFFFF_FFFF);

        // Reset in the middle of PAYLOAD (dropped frame, select=DEF_SEL).
        hdr_valid = 1'b1; hdr_ready = 1'b1; etype = 16'h0806;
        @(negedge clk);                       // LOOKUP
        @(negedge clk);                       // ROUTE, header accepted at next edge
        @(negedge clk);                       // PAYLOAD
        hdr_valid = 1'b0; hdr_ready = 1'b0;
        check("pre_rst_busy", 32'(busy), 32'd1);
        check("pre_rst_select", 32'(select), 32'(DEF_SEL));
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_enable", 32'(enable), 32'd0);
        check("mid_rst_drop", 32'(drop), 32'd0);
        check("mid_rst_select", 32'(select), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_pulses", 32'(frame_routed | frame_dropped), 32'd0);
        check("mid_rst_count", drop_count, 32'd0);
        rst = 1'b0;
        ref_drops = 32'h0;
        @(negedge clk);
        run_frame(16'hBEEF, 2, 1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
